snoop_broadcaster: RTL and testbench

- Transmit side of the inter-core snoop channel in the dual-core coherent D-cache.
- Captures local store traffic and queues invalidation requests in a small FIFO.
- Arbitrates for the shared snoop bus, then drives one-cycle snoop beats: line index, tag entry with valid bit cleared, write strobe.
- The other core's tag bank consumes these beats to invalidate matching valid lines.

---
 rtl/snoop_broadcaster.sv | 154 +++++++++++++++
 tb/tb_snoop_broadcaster.sv | 385 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/snoop_broadcaster.sv
// Snoop-channel transmitter: queues local store invalidations, wins the bus, drives beats.
// Ports: clk, rst (async active-low), st_* request in, bus_req/bus_gnt, snoop_* beat out,
// pending, idle. Optional SNOOP_COALESCE_EN drops stores matching the newest entry.
`timescale 1ns/1ps
module snoop_broadcaster #(
  parameter int ADDR_W     = 32,
  parameter int LINES      = 512,
  parameter int LINE_BYTES = 16,
  parameter int WIDTH      = 20,
  parameter int DEPTH      = 4,
  localparam int IDX_W = $clog2(LINES),
  localparam int OFF_W = $clog2(LINE_BYTES),
  localparam int TAG_W = WIDTH - 1,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1,
  localparam int ENT_W = TAG_W + IDX_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              st_valid,
  output logic              st_ready,
  input  logic [ADDR_W-1:0] st_addr,
  input  logic              st_wnr,
  output logic              bus_req,
  input  logic              bus_gnt,
  output logic              snoop_valid,
  output logic              snoop_wnr,
  output logic [IDX_W-1:0]  snoop_addr,
  output logic [WIDTH-1:0]  snoop_data,
  output logic [CNT_W-1:0]  pending,
  output logic              idle
);

  typedef enum logic [1:0] {
    IDLE,
    ARB,
    SEND
  } state_t;

  state_t             state;
  logic [ENT_W-1:0]   mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [CNT_W-1:0]   count;
  logic [CNT_W-1:0]   count_nxt;
  logic               up;
  logic               st_acc;
  logic               enq;
  logic               deq;
  logic [ENT_W-1:0]   ent;
  logic [ENT_W-1:0]   head;
  logic               unused_off;

  assign unused_off = ^st_addr[OFF_W-1:0];
  assign ent  = {st_addr[ADDR_W-1 -: TAG_W], st_addr[OFF_W +: IDX_W]};
  assign head = mem[rd_ptr];

  // up holds st_ready low until the first edge after reset release
  assign st_ready = up & (count != CNT_W'(DEPTH));
  assign st_acc   = st_valid & st_ready & st_wnr;
  assign deq      = (state == SEND);

`ifdef SNOOP_COALESCE_EN
  logic [ENT_W-1:0] newest;
  logic             newest_vld;
  logic             drop;

  // the newest entry cannot absorb a store while it is the head being sent
  assign drop = newest_vld & (newest == ent) &
                !(deq && count == CNT_W'(1));
  assign enq  = st_acc & !drop;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      newest_vld <= 1'b0;
      newest     <= '0;
    end else if (enq) begin
      newest_vld <= 1'b1;
      newest     <= ent;
    end else if (deq && count == CNT_W'(1)) begin
      newest_vld <= 1'b0;
    end
  end
`else
  assign enq = st_acc;
`endif

  assign count_nxt = count + CNT_W'(enq) - CNT_W'(deq);
  assign pending   = count;
  assign idle      = (count == '0) & (state == IDLE);

  always_ff @(posedge clk) begin
    if (enq) mem[wr_ptr] <= ent;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      up     <= 1'b0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      up    <= 1'b1;
      count <= count_nxt;
      if (enq) wr_ptr <= wr_ptr + 1'b1;
      if (deq) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      bus_req     <= 1'b0;
      snoop_valid <= 1'b0;
      snoop_wnr   <= 1'b0;
      snoop_addr  <= '0;
      snoop_data  <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (count != '0) begin
            state   <= ARB;
            bus_req <= 1'b1;
          end
        end
        ARB: begin
          if (bus_gnt) begin
            state       <= SEND;
            bus_req     <= 1'b0;
            snoop_valid <= 1'b1;
            snoop_wnr   <= 1'b1;
            snoop_addr  <= head[IDX_W-1:0];
            snoop_data  <= {1'b0, head[ENT_W-1:IDX_W]};
          end
        end
        SEND: begin
          snoop_valid <= 1'b0;
          snoop_wnr   <= 1'b0;
          if (count_nxt != '0) begin
            state   <= ARB;
            bus_req <= 1'b1;
          end else begin
            state <= IDLE;
          end
        end
        default: begin
          state   <= IDLE;
          bus_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_snoop_broadcaster.sv
// Self-checking bench for snoop_broadcaster.
// Scoreboard of expected beats, popped by a negedge monitor.
`timescale 1ns/1ps
module tb_snoop_broadcaster;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        st_valid = 1'b0;
  logic        st_ready;
  logic [31:0] st_addr = '0;
  logic        st_wnr = 1'b0;
  logic        bus_req;
  logic        bus_gnt;
  logic        snoop_valid;
  logic        snoop_wnr;
  logic [8:0]  snoop_addr;
  logic [19:0] snoop_data;
  logic [2:0]  pending;
  logic        idle;

  logic gnt_set = 1'b0;
  logic rnd_gnt = 1'b0;
  logic rnd_bit = 1'b0;

  int checks = 0;
  int errors = 0;
  int nbeats = 0;
  logic [28:0] q[$];

`ifdef SNOOP_COALESCE_EN
  localparam bit COAL = 1'b1;
`else
  localparam bit COAL = 1'b0;
`endif

  assign bus_gnt = rnd_gnt ? rnd_bit : gnt_set;

  snoop_broadcaster dut (
    .clk(clk), .rst(rst),
    .st_valid(st_valid), .st_ready(st_ready),
    .st_addr(st_addr), .st_wnr(st_wnr),
    .bus_req(bus_req), .bus_gnt(bus_gnt),
    .snoop_valid(snoop_valid), .snoop_wnr(snoop_wnr),
    .snoop_addr(snoop_addr), .snoop_data(snoop_data),
    .pending(pending), .idle(idle)
  );

  always #5 clk = ~clk;

  always @(negedge clk) rnd_bit <= 1'($urandom_range(0, 1));

  function automatic logic [28:0] exp_of(input logic [31:0] a);
    return {a[12:4], 1'b0, a[31:13]};
  endfunction

  always @(negedge clk) begin
    logic [28:0] e;
    if (rst && snoop_valid) begin
      nbeats++;
      checks++;
      if (snoop_wnr !== 1'b1) begin
        errors++;
        $display("FAIL beat_wnr: got %b want 1", snoop_wnr);
      end
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL beat_unexpected: got addr=%h data=%h want none",
                 snoop_addr, snoop_data);
      end else begin
        e = q.pop_front();
        if ({snoop_addr, snoop_data} !== e) begin
          errors++;
          $display("FAIL beat_order: got addr=%h data=%h want addr=%h data=%h",
                   snoop_addr, snoop_data, e[28:20], e[19:0]);
        end
      end
    end
  end

  task automatic put(input logic [31:0] a, input logic w,
                     input bit push, output bit ok);
    st_addr  = a;
    st_wnr   = w;
    st_valid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (st_ready) begin
        if (push) q.push_back(exp_of(a));
        @(posedge clk);
        @(negedge clk);
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    st_valid = 1'b0;
  endtask

  task automatic wait_drain(input string nm);
    for (int i = 0; i < 300; i++) begin
      if (q.size() == 0 && idle === 1'b1) break;
      @(negedge clk);
    end
    checks++;
    if (!(q.size() == 0 && idle === 1'b1)) begin
      errors++;
      $display("FAIL %s_drain: got left=%0d idle=%b want left=0 idle=1",
               nm, q.size(), idle);
    end
  endtask

  task automatic test_reset;
    rst = 1'b0;
    #12;
    checks++;
    if ({st_ready, bus_req, snoop_valid, snoop_wnr} !== 4'b0000) begin
      errors++;
      $display("FAIL rst_ctrl: got rdy/req/vld/wnr=%b want 0000",
               {st_ready, bus_req, snoop_valid, snoop_wnr});
    end
    checks++;
    if ({snoop_addr, snoop_data} !== 29'h0) begin
      errors++;
      $display("FAIL rst_data: got %h want 0", {snoop_addr, snoop_data});
    end
    checks++;
    if (pending !== 3'd0 || idle !== 1'b1) begin
      errors++;
      $display("FAIL rst_occ: got pending=%0d idle=%b want 0 1", pending, idle);
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if (st_ready !== 1'b0) begin
      errors++;
      $display("FAIL rst_ready_early: got %b want 0", st_ready);
    end
    @(negedge clk);
    checks++;
    if (st_ready !== 1'b1) begin
      errors++;
      $display("FAIL rst_ready_rise: got %b want 1", st_ready);
    end
  endtask

  task automatic test_basic;
    bit ok;
    gnt_set = 1'b1;
    put(32'h0000_1230, 1'b1, 1'b1, ok);
    checks++;
    if (!ok || pending !== 3'd1 || bus_req !== 1'b0) begin
      errors++;
      $display("FAIL basic_c1: got ok=%b pending=%0d req=%b want 1 1 0",
               ok, pending, bus_req);
    end
    @(negedge clk);
    checks++;
    if (bus_req !== 1'b1 || snoop_valid !== 1'b0) begin
      errors++;
      $display("FAIL basic_c2: got req=%b vld=%b want 1 0", bus_req, snoop_valid);
    end
    @(negedge clk);
    checks++;
    if (snoop_valid !== 1'b1 || snoop_addr !== 9'h123 ||
        snoop_data !== 20'h00000 || bus_req !== 1'b0) begin
      errors++;
      $display("FAIL basic_c3: got vld=%b addr=%h data=%h req=%b want 1 123 00000 0",
               snoop_valid, snoop_addr, snoop_data, bus_req);
    end
    @(negedge clk);
    checks++;
    if (idle !== 1'b1 || snoop_valid !== 1'b0) begin
      errors++;
      $display("FAIL basic_c4: got idle=%b vld=%b want 1 0", idle, snoop_valid);
    end
  endtask

  task automatic test_load;
    bit ok;
    int bad = 0;
    gnt_set = 1'b1;
    put(32'h0000_1230, 1'b0, 1'b0, ok);
    checks++;
    if (!ok || pending !== 3'd0) begin
      errors++;
      $display("FAIL load_acc: got ok=%b pending=%0d want 1 0", ok, pending);
    end
    repeat (8) begin
      if (bus_req !== 1'b0 || snoop_valid !== 1'b0) bad++;
      @(negedge clk);
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL load_quiet: got %0d busy cycles want 0", bad);
    end
  endtask

  task automatic test_full;
    bit ok;
    int stall = 0;
    logic [31:0] a;
    gnt_set = 1'b0;
    for (int i = 0; i < 4; i++) begin
      a = 32'h0002_0000 * i + 32'h100 * (i + 1);
      put(a, 1'b1, 1'b1, ok);
      checks++;
      if (!ok) begin
        errors++;
        $display("FAIL full_acc%0d: got 0 want 1", i);
      end
    end
    checks++;
    if (pending !== 3'd4 || st_ready !== 1'b0) begin
      errors++;
      $display("FAIL full_state: got pending=%0d rdy=%b want 4 0", pending, st_ready);
    end
    a = 32'hDEAD_BEE0;
    st_addr = a;
    st_wnr = 1'b1;
    st_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (st_ready !== 1'b0) stall++;
    end
    checks++;
    if (stall != 0) begin
      errors++;
      $display("FAIL full_stall: got %0d ready cycles want 0", stall);
    end
    gnt_set = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (st_ready) begin
        q.push_back(exp_of(a));
        @(posedge clk);
        @(negedge clk);
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    st_valid = 1'b0;
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL full_fifth: got not accepted want accepted");
    end
    wait_drain("full");
  endtask

  task automatic test_withhold;
    bit ok;
    int bad = 0;
    gnt_set = 1'b0;
    put(32'hABCD_E5F0, 1'b1, 1'b1, ok);
    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      if (bus_req !== 1'b1 || snoop_valid !== 1'b0) bad++;
      if (i < 9) @(negedge clk);
    end
    checks++;
    if (!ok || bad != 0) begin
      errors++;
      $display("FAIL hold_arb: got ok=%b bad=%0d want 1 0", ok, bad);
    end
    gnt_set = 1'b1;
    @(negedge clk);
    checks++;
    if (snoop_valid !== 1'b1) begin
      errors++;
      $display("FAIL hold_beat: got %b want 1", snoop_valid);
    end
    wait_drain("hold");
  endtask

  task automatic test_reset_mid;
    bit ok;
    bit seen = 1'b0;
    int nb0;
    gnt_set = 1'b0;
    for (int i = 0; i < 3; i++) put(32'h0000_4000 + 32'h10 * i, 1'b1, 1'b1, ok);
    gnt_set = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (snoop_valid === 1'b1) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL rmid_beat: got no beat want beat");
    end
    rst = 1'b0;
    #1;
    checks++;
    if (snoop_valid !== 1'b0 || bus_req !== 1'b0 || pending !== 3'd0) begin
      errors++;
      $display("FAIL rmid_drop: got vld=%b req=%b pending=%0d want 0 0 0",
               snoop_valid, bus_req, pending);
    end
    q.delete();
    nb0 = nbeats;
    @(negedge clk);
    rst = 1'b1;
    repeat (10) @(negedge clk);
    checks++;
    if (nbeats != nb0 || idle !== 1'b1) begin
      errors++;
      $display("FAIL rmid_flush: got beats=%0d idle=%b want 0 1",
               nbeats - nb0, idle);
    end
  endtask

  task automatic test_coalesce;
    bit ok1, ok2;
    int nb0;
    logic [2:0] want;
    want = COAL ? 3'd1 : 3'd2;
    gnt_set = 1'b0;
    put(32'h8000_0040, 1'b1, 1'b1, ok1);
    put(32'h8000_0040, 1'b1, !COAL, ok2);
    checks++;
    if (!ok1 || !ok2 || pending !== want) begin
      errors++;
      $display("FAIL coal_pending: got ok=%b%b pending=%0d want 11 %0d",
               ok1, ok2, pending, want);
    end
    nb0 = nbeats;
    gnt_set = 1'b1;
    wait_drain("coal");
    checks++;
    if (nbeats - nb0 != int'(want)) begin
      errors++;
      $display("FAIL coal_beats: got %0d want %0d", nbeats - nb0, want);
    end
  endtask

  task automatic test_back_to_back;
    bit ok;
    int stalls = 0;
    logic [31:0] a;
    logic w;
    rnd_gnt = 1'b1;
    for (int i = 0; i < 40; i++) begin
      a = $urandom;
      w = ($urandom_range(0, 3) != 0);
      put(a, w, w, ok);
      if (!ok) stalls++;
    end
    checks++;
    if (stalls != 0) begin
      errors++;
      $display("FAIL b2b_accept: got %0d timeouts want 0", stalls);
    end
    rnd_gnt = 1'b0;
    gnt_set = 1'b1;
    wait_drain("b2b");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_basic();
    test_load();
    test_full();
    test_withhold();
    test_reset_mid();
    test_coalesce();
    test_back_to_back();
    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
